ch_bank_sequencer: RTL and testbench

Downstream consumer of the channel mode decoder's start1/start2/start4 pulses. It arms the four fast sampling banks in groups according to the selected mode and keeps each group writing until a trigger arrives. After the trigger it holds the group for a programmable post-trigger delay, then freezes that group and advances to the next. It reports busy, done and the event count to the channel readout logic.

---
 rtl/ch_bank_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ch_bank_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ch_bank_sequencer.sv
// Arms fast sampling banks in mode-dependent groups, holds each group post_trig+1 cycles after a trigger, then advances.
// Latency: bank_en 2 edges after a start level is first sampled, POST 3 edges after trig_in; no backpressure, inputs never stall.
module ch_bank_sequencer #(
    parameter int POST_W    = 8,
    parameter int NUM_BANKS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start1,
    input  logic              start2,
    input  logic              start4,
    input  logic              trig_in,
    input  logic              abort,
    input  logic [POST_W-1:0] post_trig,
    output logic [3:0]        bank_en,
    output logic              busy,
    output logic              done,
    output logic [1:0]        grp_idx,
    output logic [2:0]        ev_cnt
);

    generate
        if (NUM_BANKS != 4) begin : g_bad_banks
            $error("ch_bank_sequencer supports NUM_BANKS == 4 only");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_POST   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE4 = 2'd2
    } mode_t;

    state_t            state, state_nxt;
    mode_t             mode, mode_nxt;
    logic [1:0]        grp_nxt;
    logic [2:0]        ev_nxt;
    logic [POST_W-1:0] cnt, cnt_nxt;

    logic [2:0]        start_q;
    logic [2:0]        start_edge;
    logic              trig_s1, trig_s2, trig_s2_q;
    logic              trig_edge;

    function automatic logic [3:0] grp_mask(input mode_t m, input logic [1:0] g);
        logic [3:0] r;
        r = 4'b0000;
        case (m)
            MODE1:   r = 4'b0001 << g;
            MODE2:   r = (g == 2'd0) ? 4'b0011 : 4'b1100;
            MODE4:   r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] last_grp(input mode_t m);
        logic [1:0] r;
        r = 2'd0;
        case (m)
            MODE1:   r = 2'd3;
            MODE2:   r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Start edges are registered so one sequence launches per rising edge regardless of pulse width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q    <= 3'b000;
            start_edge <= 3'b000;
        end else begin
            start_q    <= {start4, start2, start1};
            start_edge <= {start4, start2, start1} & ~start_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_s2_q <= 1'b0;
        end else begin
            trig_s1   <= trig_in;
            trig_s2   <= trig_s1;
            trig_s2_q <= trig_s2;
        end
    end

    assign trig_edge = trig_s2 & ~trig_s2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            mode    <= MODE1;
            grp_idx <= 2'd0;
            ev_cnt  <= 3'd0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            mode    <= mode_nxt;
            grp_idx <= grp_nxt;
            ev_cnt  <= ev_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        grp_nxt   = grp_idx;
        ev_nxt    = ev_cnt;
        cnt_nxt   = cnt;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|start_edge) begin
                        if (start_edge[2])      mode_nxt = MODE4;
                        else if (start_edge[1]) mode_nxt = MODE2;
                        else                    mode_nxt = MODE1;
                        grp_nxt   = 2'd0;
                        ev_nxt    = 3'd0;
                        state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (trig_edge) begin
                        cnt_nxt   = post_trig;
                        ev_nxt    = ev_cnt + 3'd1;
                        state_nxt = ST_POST;
                    end
                end
                ST_POST: begin
                    // Triggers seen here are dropped; the next group needs a fresh edge.
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (grp_idx == last_grp(mode)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        grp_nxt   = grp_idx + 2'd1;
                        state_nxt = ST_SAMPLE;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Mask decodes straight from registered group index, so freeze and next-arm share one edge.
    assign bank_en = ((state == ST_SAMPLE) || (state == ST_POST)) ? grp_mask(mode, grp_idx) : 4'b0000;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_ch_bank_sequencer.sv
// Directed bench for ch_bank_sequencer: mode sequencing, trigger sync timing, abort and async reset.
module tb_ch_bank_sequencer;

    logic       clk;
    logic       rstn;
    logic       start1, start2, start4;
    logic       trig_in;
    logic       abort;
    logic [7:0] post_trig;
    logic [3:0] bank_en;
    logic       busy;
    logic       done;
    logic [1:0] grp_idx;
    logic [2:0] ev_cnt;

    int vectors = 0;
    int errors  = 0;

    ch_bank_sequencer #(.POST_W(8), .NUM_BANKS(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start1    (start1),
        .start2    (start2),
        .start4    (start4),
        .trig_in   (trig_in),
        .abort     (abort),
        .post_trig (post_trig),
        .bank_en   (bank_en),
        .busy      (busy),
        .done      (done),
        .grp_idx   (grp_idx),
        .ev_cnt    (ev_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        trig_in = 1'b0; abort = 1'b0; post_trig = 8'd0;
        tick(3);
        chk("rst_bank_en", {4'b0, bank_en}, 8'h0);
        chk("rst_busy",    {7'b0, busy},    8'h0);
        chk("rst_done",    {7'b0, done},    8'h0);
        chk("rst_grp",     {6'b0, grp_idx}, 8'h0);
        chk("rst_ev",      {5'b0, ev_cnt},  8'h0);
        rstn = 1'b1;
        tick(2);

        // mode4, 3-cycle start pulse, post_trig=5 with a mid-POST change that must be ignored
        post_trig = 8'd5;
        start4 = 1'b1;
        tick();
        chk("m4_not_yet_busy", {7'b0, busy}, 8'h0);
        tick();
        chk("m4_bank_en", {4'b0, bank_en}, 8'h0f);
        chk("m4_busy",    {7'b0, busy},    8'h1);
        tick();
        start4 = 1'b0;
        trig_in = 1'b1;
        tick(2);
        chk("m4_sync_wait_ev", {5'b0, ev_cnt}, 8'h0);
        trig_in = 1'b0;
        tick();
        chk("m4_post_ev", {5'b0, ev_cnt}, 8'h1);
        post_trig = 8'd0;
        tick(5);
        chk("m4_post_hold", {4'b0, bank_en}, 8'h0f);
        chk("m4_no_done_yet", {7'b0, done}, 8'h0);
        tick();
        chk("m4_done",      {7'b0, done},    8'h1);
        chk("m4_done_bank", {4'b0, bank_en}, 8'h0);
        chk("m4_done_busy", {7'b0, busy},    8'h1);
        tick();
        chk("m4_idle_done", {7'b0, done},    8'h0);
        chk("m4_idle_busy", {7'b0, busy},    8'h0);
        chk("m4_ev_final",  {5'b0, ev_cnt},  8'h1);
        chk("m4_grp_final", {6'b0, grp_idx}, 8'h0);

        // mode1, post_trig=0, four triggers 10 cycles apart, then a stray fifth
        start1 = 1'b1;
        tick(2);
        start1 = 1'b0;
        chk("m1_bank0", {4'b0, bank_en}, 8'h01);
        for (int g = 0; g < 4; g++) begin
            trig_in = 1'b1;
            tick();
            trig_in = 1'b0;
            tick(2);
            chk("m1_post_bank", {4'b0, bank_en}, 8'(4'b0001 << g));
            chk("m1_post_ev",   {5'b0, ev_cnt},  8'(g + 1));
            tick();
            if (g < 3) begin
                chk("m1_next_bank", {4'b0, bank_en}, 8'(4'b0001 << (g + 1)));
                chk("m1_next_grp",  {6'b0, grp_idx}, 8'(g + 1));
            end else begin
                chk("m1_done",      {7'b0, done},    8'h1);
                chk("m1_done_bank", {4'b0, bank_en}, 8'h0);
            end
            tick(6);
        end
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick(5);
        chk("m1_fifth_ev",   {5'b0, ev_cnt},  8'h4);
        chk("m1_fifth_busy", {7'b0, busy},    8'h0);
        chk("m1_fifth_grp",  {6'b0, grp_idx}, 8'h3);

        // mode2, trigger level held across the group change
        post_trig = 8'd1;
        start2 = 1'b1;
        tick(2);
        start2 = 1'b0;
        chk("m2_bank0", {4'b0, bank_en}, 8'h03);
        trig_in = 1'b1;
        tick(3);
        chk("m2_post_ev", {5'b0, ev_cnt}, 8'h1);
        tick(2);
        chk("m2_bank1", {4'b0, bank_en}, 8'h0c);
        chk("m2_grp1",  {6'b0, grp_idx}, 8'h1);
        tick(5);
        chk("m2_level_no_event", {5'b0, ev_cnt},  8'h1);
        chk("m2_level_bank",     {4'b0, bank_en}, 8'h0c);
        trig_in = 1'b0;
        tick(3);
        trig_in = 1'b1;
        tick(3);
        chk("m2_second_ev", {5'b0, ev_cnt}, 8'h2);
        trig_in = 1'b0;
        tick(2);
        chk("m2_done", {7'b0, done}, 8'h1);
        tick();
        chk("m2_idle_ev",  {5'b0, ev_cnt},  8'h2);
        chk("m2_idle_grp", {6'b0, grp_idx}, 8'h1);

        // simultaneous start1+start4 picks mode4; start2 while busy ignored
        post_trig = 8'd0;
        start1 = 1'b1; start4 = 1'b1;
        tick(2);
        start1 = 1'b0; start4 = 1'b0;
        chk("prio_bank", {4'b0, bank_en}, 8'h0f);
        tick();
        start2 = 1'b1;
        tick(2);
        start2 = 1'b0;
        chk("busy_start2_bank", {4'b0, bank_en}, 8'h0f);
        chk("busy_start2_ev",   {5'b0, ev_cnt},  8'h0);
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick(3);
        chk("prio_done", {7'b0, done}, 8'h1);
        tick(2);
        chk("prio_idle_busy", {7'b0, busy}, 8'h0);

        // abort in SAMPLE, mode2 group 1
        start2 = 1'b1;
        tick(2);
        start2 = 1'b0;
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick(3);
        chk("ab_bank1", {4'b0, bank_en}, 8'h0c);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_bank", {4'b0, bank_en}, 8'h0);
        chk("ab_busy", {7'b0, busy},    8'h0);
        chk("ab_done", {7'b0, done},    8'h0);
        chk("ab_ev",   {5'b0, ev_cnt},  8'h1);
        chk("ab_grp",  {6'b0, grp_idx}, 8'h1);
        tick();
        chk("ab_no_late_done", {7'b0, done}, 8'h0);

        // async reset mid-POST in mode2, then a clean mode1 start
        post_trig = 8'd20;
        start2 = 1'b1;
        tick(2);
        start2 = 1'b0;
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick(2);
        chk("rp_post_ev", {5'b0, ev_cnt}, 8'h1);
        #1 rstn = 1'b0;
        #1;
        chk("rp_bank", {4'b0, bank_en}, 8'h0);
        chk("rp_busy", {7'b0, busy},    8'h0);
        chk("rp_ev",   {5'b0, ev_cnt},  8'h0);
        tick();
        rstn = 1'b1;
        tick();
        start1 = 1'b1;
        tick(2);
        start1 = 1'b0;
        chk("rp_restart_bank", {4'b0, bank_en}, 8'h01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rp_abort_busy", {7'b0, busy}, 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
